button_event_decoder: RTL and testbench

- Sits directly downstream of the two-channel push-button debouncer and consumes its two clean button levels.
- Converts each level into one-cycle event pulses: short press, long press and auto-repeat while held.
- Emits a separate combo event when both buttons are pressed together; that event suppresses the per-button events until both buttons are released.
- Event pulses drive the control logic of the FPGA lab project (mode/counter control).

---
 rtl/button_event_if.sv | 25 ++
 rtl/button_event_decoder.sv | 177 +++++++++++++++++
 tb/tb_button_event_decoder.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/button_event_if.sv
// Bundle between the debouncer-side producer and the button event decoder:
// two clean button levels in, seven one-cycle event pulses out.
interface button_event_if;
  logic btn1;
  logic btn2;
  logic short1;
  logic long1;
  logic rep1;
  logic short2;
  logic long2;
  logic rep2;
  logic combo;

  // Producer of button levels, consumer of events.
  modport master (
    output btn1, btn2,
    input  short1, long1, rep1, short2, long2, rep2, combo
  );

  // The decoder itself.
  modport slave (
    input  btn1, btn2,
    output short1, long1, rep1, short2, long2, rep2, combo
  );
endinterface

// File: rtl/button_event_decoder.sv
// Turns two debounced button levels into one-cycle short / long / repeat
// pulses per button, plus a combo pulse when both are pressed together.
// A combo locks both buttons until both have been released.
module button_event_decoder #(
  parameter int LONG_CYCLES   = 25000000,
  parameter int REPEAT_CYCLES = 5000000,
  parameter int CNT_W         = 25
) (
  input logic           clk,
  input logic           rst,
  button_event_if.slave bus
);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESS = 2'd1, LONG = 2'd2, LOCK = 2'd3} state_t;

  typedef struct packed {
    state_t           st;
    logic [CNT_W-1:0] cnt;
    logic             sp;
    logic             lp;
    logic             rp;
  } btn_nx_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           st1_r, st2_r, st1_s, st2_s;
  logic [CNT_W-1:0] cnt1_r, cnt2_r, cnt1_s, cnt2_s;
  logic             lock_r, lock_s;
  logic             short1_r, long1_r, rep1_r, short2_r, long2_r, rep2_r, combo_r;
  logic             short1_s, long1_s, rep1_s, short2_s, long2_s, rep2_s, combo_s;
  btn_nx_t          n1_s, n2_s;

  // Per-button rules, used only when no combo/lock decision overrides them.
  function automatic btn_nx_t btn_step(input state_t st, input logic [CNT_W-1:0] cnt,
                                       input logic btn);
    btn_nx_t r;
    r.st  = st;
    r.cnt = cnt;
    r.sp  = 1'b0;
    r.lp  = 1'b0;
    r.rp  = 1'b0;
    case (st)
      IDLE: begin
        if (btn) begin
          r.st  = PRESS;
          r.cnt = CNT_ZERO;
        end else begin
          r.cnt = CNT_ZERO;
        end
      end
      PRESS: begin
        // Release wins over a simultaneous long-threshold hit.
        if (!btn) begin
          r.sp  = 1'b1;
          r.st  = IDLE;
          r.cnt = CNT_ZERO;
        end else if (cnt == LONG_LAST) begin
          r.lp  = 1'b1;
          r.st  = LONG;
          r.cnt = CNT_ZERO;
        end else begin
          r.cnt = cnt + CNT_ONE;
        end
      end
      LONG: begin
        if (!btn) begin
          r.st  = IDLE;
          r.cnt = CNT_ZERO;
        end else if (cnt == REP_LAST) begin
          r.rp  = 1'b1;
          r.cnt = CNT_ZERO;
        end else begin
          r.cnt = cnt + CNT_ONE;
        end
      end
      LOCK: begin
        r.cnt = CNT_ZERO;
      end
      default: begin
        r.st  = IDLE;
        r.cnt = CNT_ZERO;
      end
    endcase
    return r;
  endfunction

  // Next-state and pulse decode: combo/lock take precedence over per-button rules.
  always_comb begin
    st1_s    = st1_r;
    st2_s    = st2_r;
    cnt1_s   = cnt1_r;
    cnt2_s   = cnt2_r;
    lock_s   = lock_r;
    short1_s = 1'b0;
    long1_s  = 1'b0;
    rep1_s   = 1'b0;
    short2_s = 1'b0;
    long2_s  = 1'b0;
    rep2_s   = 1'b0;
    combo_s  = 1'b0;
    n1_s     = btn_step(st1_r, cnt1_r, bus.btn1);
    n2_s     = btn_step(st2_r, cnt2_r, bus.btn2);
    if (bus.btn1 && bus.btn2 && !lock_r && (st1_r != LONG) && (st2_r != LONG)) begin
      combo_s = 1'b1;
      lock_s  = 1'b1;
      st1_s   = LOCK;
      st2_s   = LOCK;
      cnt1_s  = CNT_ZERO;
      cnt2_s  = CNT_ZERO;
    end else if (lock_r) begin
      cnt1_s = CNT_ZERO;
      cnt2_s = CNT_ZERO;
      if (!bus.btn1 && !bus.btn2) begin
        lock_s = 1'b0;
        st1_s  = IDLE;
        st2_s  = IDLE;
      end else begin
        st1_s  = LOCK;
        st2_s  = LOCK;
      end
    end else begin
      st1_s    = n1_s.st;
      cnt1_s   = n1_s.cnt;
      short1_s = n1_s.sp;
      long1_s  = n1_s.lp;
      rep1_s   = n1_s.rp;
      st2_s    = n2_s.st;
      cnt2_s   = n2_s.cnt;
      short2_s = n2_s.sp;
      long2_s  = n2_s.lp;
      rep2_s   = n2_s.rp;
    end
  end

  // State, counters, lock and registered event pulses; rst aborts any press.
  always_ff @(posedge clk) begin
    if (rst) begin
      st1_r    <= IDLE;
      st2_r    <= IDLE;
      cnt1_r   <= CNT_ZERO;
      cnt2_r   <= CNT_ZERO;
      lock_r   <= 1'b0;
      short1_r <= 1'b0;
      long1_r  <= 1'b0;
      rep1_r   <= 1'b0;
      short2_r <= 1'b0;
      long2_r  <= 1'b0;
      rep2_r   <= 1'b0;
      combo_r  <= 1'b0;
    end else begin
      st1_r    <= st1_s;
      st2_r    <= st2_s;
      cnt1_r   <= cnt1_s;
      cnt2_r   <= cnt2_s;
      lock_r   <= lock_s;
      short1_r <= short1_s;
      long1_r  <= long1_s;
      rep1_r   <= rep1_s;
      short2_r <= short2_s;
      long2_r  <= long2_s;
      rep2_r   <= rep2_s;
      combo_r  <= combo_s;
    end
  end

  assign bus.short1 = short1_r;
  assign bus.long1  = long1_r;
  assign bus.rep1   = rep1_r;
  assign bus.short2 = short2_r;
  assign bus.long2  = long2_r;
  assign bus.rep2   = rep2_r;
  assign bus.combo  = combo_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Bench for button_event_decoder: directed scenarios followed by random
// button activity, scored against a hold-duration reference model.
module tb_button_event_decoder;

  localparam int L = 8;
  localparam int R = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  button_event_if bus();

  button_event_decoder #(.LONG_CYCLES(L), .REPEAT_CYCLES(R), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cyc;
    logic [6:0] ev;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   done     = 1'b0;

  // Reference state: edges each button has been held in the current press,
  // and whether a combo lock is active.
  int   held1 = 0;
  int   held2 = 0;
  bit   lock_m = 1'b0;

  wire [6:0] dut_ev = {bus.combo, bus.rep2, bus.long2, bus.short2,
                       bus.rep1, bus.long1, bus.short1};

  // Count rising edges so expectations can be tagged with the cycle they appear in.
  always @(posedge clk) cyc <= cyc + 1;

  // One button: pulses follow from how long it has been held.
  task automatic btn_model(input logic b, inout int held, output logic s, output logic l,
                           output logic rp);
    s = 1'b0; l = 1'b0; rp = 1'b0;
    if (b) begin
      held++;
      if (held - 1 == L) l = 1'b1;
      else if (held - 1 > L && ((held - 1 - L) % R) == 0) rp = 1'b1;
    end else begin
      if (held > 0 && held <= L) s = 1'b1;
      held = 0;
    end
  endtask

  task automatic model_step(input logic b1, input logic b2, input logic r, output logic [6:0] ev);
    logic s1, l1, p1, s2, l2, p2;
    ev = 7'd0;
    if (r) begin
      held1 = 0; held2 = 0; lock_m = 1'b0;
    end else if (b1 && b2 && !lock_m && held1 <= L && held2 <= L) begin
      ev = 7'b1000000;
      lock_m = 1'b1; held1 = 0; held2 = 0;
    end else if (lock_m) begin
      if (!b1 && !b2) lock_m = 1'b0;
    end else begin
      btn_model(b1, held1, s1, l1, p1);
      btn_model(b2, held2, s2, l2, p2);
      ev = {1'b0, p2, l2, s2, p1, l1, s1};
    end
  endtask

  // Drive inputs for the next rising edge and queue what must appear after it.
  task automatic apply(input logic b1, input logic b2, input logic r);
    logic [6:0] ev;
    exp_t e;
    @(negedge clk);
    bus.btn1 = b1;
    bus.btn2 = b2;
    rst      = r;
    model_step(b1, b2, r, ev);
    if (ev != 7'd0) begin
      e.cyc = cyc + 1;
      e.ev  = ev;
      exp_q.push_back(e);
    end
  endtask

  task automatic seg(input logic b1, input logic b2, input int n);
    for (int i = 0; i < n; i++) apply(b1, b2, 1'b0);
  endtask

  // Monitor: every pulse must match the queue head; overdue entries are misses.
  always @(negedge clk) begin
    if (!done) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event cycle=%0d actual=0000000 required=%b", exp_q[0].cyc, exp_q[0].ev);
        void'(exp_q.pop_front());
      end
      if (dut_ev != 7'd0) begin
        checks++;
        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
          failures++;
          $display("FAIL unexpected_event cycle=%0d actual=%b required=0000000", cyc, dut_ev);
        end else begin
          if (exp_q[0].ev != dut_ev) begin
            failures++;
            $display("FAIL event_bits cycle=%0d actual=%b required=%b", cyc, dut_ev, exp_q[0].ev);
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bus.btn1 = 1'b0;
    bus.btn2 = 1'b0;
    apply(1'b0, 1'b0, 1'b1);
    apply(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1;
    checks++;
    if (dut_ev !== 7'd0) begin
      failures++;
      $display("FAIL reset_state actual=%b required=0000000", dut_ev);
    end

    // Idle after reset, then the directed scenarios.
    seg(1'b0, 1'b0, 20);
    seg(1'b1, 1'b0, 3);  seg(1'b0, 1'b0, 5);
    seg(1'b0, 1'b1, 20); seg(1'b0, 1'b0, 5);
    seg(1'b1, 1'b1, 5);  seg(1'b0, 1'b1, 2); seg(1'b0, 1'b0, 3);
    seg(1'b1, 1'b0, 3);  seg(1'b0, 1'b0, 4);
    seg(1'b1, 1'b0, 10); seg(1'b1, 1'b1, 2); seg(1'b1, 1'b0, 8); seg(1'b0, 1'b0, 4);
    seg(1'b1, 1'b0, 5);  apply(1'b1, 1'b0, 1'b1); seg(1'b1, 1'b0, 12); seg(1'b0, 1'b0, 4);
    // Lock: re-press one button while the other stays held.
    seg(1'b1, 1'b1, 2);  seg(1'b1, 1'b0, 3); seg(1'b1, 1'b1, 3); seg(1'b0, 1'b1, 12);
    seg(1'b0, 1'b0, 3);

    // Random activity with occasional resets.
    for (int k = 0; k < 400; k++) begin
      logic rb1, rb2;
      rb1 = 1'($urandom_range(0, 1));
      rb2 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 49) == 0) apply(rb1, rb2, 1'b1);
      seg(rb1, rb2, int'($urandom_range(1, 16)));
    end
    seg(1'b0, 1'b0, 5);
    @(negedge clk);
    @(negedge clk);
    done = 1'b1;

    while (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL missed_event cycle=%0d actual=0000000 required=%b", exp_q[0].cyc, exp_q[0].ev);
      void'(exp_q.pop_front());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
